// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared FSM state encoding, opmode constants and widths for the DSP MAC
// sequencer and its drain counter.
package dsp_mac_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] OPMODE_MAC_DFLT  = 8'h09;
  localparam logic [7:0] OPMODE_IDLE_DFLT = 8'h00;

  localparam int unsigned PIPE_LAT_MAX = 7;
  localparam int unsigned DRAIN_W      = 3;
  localparam int unsigned LEN_W        = 8;
  localparam int unsigned OPND_W       = 18;
  localparam int unsigned ACC_W        = 48;

endpackage

// File: rtl/mac_drain_counter.sv
// Loadable down-counter that times the DSP pipeline drain; tc_o is high once
// the count has reached zero.
module mac_drain_counter
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [DRAIN_W-1:0] count_q;
  logic [DRAIN_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = DRAIN_W'(LOAD_VAL);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a dot-product job through an external DSP slice: clears P, feeds
// operand pairs, drains the pipeline and hands the accumulated sum back.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int unsigned PIPE_LAT    = 3,
  parameter logic [7:0]  OPMODE_MAC  = OPMODE_MAC_DFLT,
  parameter logic [7:0]  OPMODE_IDLE = OPMODE_IDLE_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [OPND_W-1:0] in_a,
  input  logic signed [OPND_W-1:0] in_b,
  output logic signed [OPND_W-1:0] dsp_a,
  output logic signed [OPND_W-1:0] dsp_b,
  output logic [7:0]               dsp_opmode,
  output logic                     dsp_ce,
  output logic                     dsp_rstp,
  input  logic signed [ACC_W-1:0]  dsp_p,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  result
);

  state_e                  state_q;
  state_e                  state_d;
  logic [LEN_W-1:0]        remain_q;
  logic [LEN_W-1:0]        remain_d;
  logic signed [OPND_W-1:0] dsp_a_q;
  logic signed [OPND_W-1:0] dsp_a_d;
  logic signed [OPND_W-1:0] dsp_b_q;
  logic signed [OPND_W-1:0] dsp_b_d;
  logic signed [ACC_W-1:0] result_q;
  logic signed [ACC_W-1:0] result_d;
  logic                    xfer;
  logic                    last_xfer;
  logic                    drain_en;
  logic                    drain_tc;

  assign xfer      = (state_q == ST_FEED) && in_valid;
  assign last_xfer = xfer && (remain_q == LEN_W'(1));
  assign drain_en  = (state_q == ST_DRAIN);

  // Loaded on the last transfer so the capture lands PIPE_LAT+1 edges later.
  mac_drain_counter #(
    .LOAD_VAL (PIPE_LAT)
  ) u_drain (
    .clk    (clk),
    .rst    (rst),
    .load_i (last_xfer),
    .en_i   (drain_en),
    .tc_o   (drain_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED:  if (last_xfer) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_tc) state_d = ST_DONE;
      ST_DONE:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operands are zero on any cycle without a transfer, so bubbles add nothing.
  always_comb begin
    remain_d = remain_q;
    result_d = result_q;
    dsp_a_d  = '0;
    dsp_b_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = len;
          if (len == '0) result_d = '0;
        end
      end
      ST_FEED: begin
        if (in_valid) begin
          remain_d = remain_q - LEN_W'(1);
          dsp_a_d  = in_a;
          dsp_b_d  = in_b;
        end
      end
      ST_DRAIN: if (drain_tc) result_d = dsp_p;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= '0;
      result_q <= '0;
      dsp_a_q  <= '0;
      dsp_b_q  <= '0;
    end else begin
      remain_q <= remain_d;
      result_q <= result_d;
      dsp_a_q  <= dsp_a_d;
      dsp_b_q  <= dsp_b_d;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    in_ready   = (state_q == ST_FEED);
    res_valid  = (state_q == ST_DONE);
    dsp_ce     = (state_q != ST_IDLE);
    dsp_opmode = (state_q != ST_IDLE) ? OPMODE_MAC : OPMODE_IDLE;
    dsp_rstp   = rst || (state_q == ST_CLEAR);
  end

  assign dsp_a  = dsp_a_q;
  assign dsp_b  = dsp_b_q;
  assign result = result_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a 3-stage DSP slice model and a
// rule-based per-cycle reference model.
module tb_dsp_mac_sequencer;

  localparam int         LAT     = 3;
  localparam logic [7:0] OP_MAC  = 8'h09;
  localparam logic [7:0] OP_IDLE = 8'h00;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         len;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic               dsp_rstp;
  logic signed [47:0] dsp_p;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic signed [47:0] result;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .PIPE_LAT    (LAT),
    .OPMODE_MAC  (OP_MAC),
    .OPMODE_IDLE (OP_IDLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rstp   (dsp_rstp),
    .dsp_p      (dsp_p),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result)
  );

  // DSP slice: A/B reg, M reg, P reg; the reset pin clears the whole pipe.
  logic signed [47:0] sl_a, sl_b, sl_m, sl_p;
  always @(posedge clk) begin
    if (dsp_rstp) begin
      sl_a <= '0;
      sl_b <= '0;
      sl_m <= '0;
      sl_p <= '0;
    end else if (dsp_ce) begin
      sl_a <= {{30{dsp_a[17]}}, dsp_a};
      sl_b <= {{30{dsp_b[17]}}, dsp_b};
      sl_m <= sl_a * sl_b;
      if (dsp_opmode == OP_MAC) sl_p <= sl_p + sl_m;
    end
  end
  assign dsp_p = sl_p;

  int     total = 0;
  int     bad = 0;
  int     lit_seq = 0;
  longint lit_val = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expectations for the next cycle follow from the job
  // rules (transfers counted, LAT+1 edges of drain after the last one).
  initial begin : cmp
    bit     init = 0, active = 0, clear_c = 0, e_ir = 0, e_rv = 0, xfer, new_rv;
    int     remaining = 0, since = 0, jlen = 0, done_seq = 0, jobs = 0;
    longint e_a = 0, e_b = 0, sum = 0, e_res = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (init) chk("rstp_during_rst", longint'(dsp_rstp), 1);
        init = 1; active = 0; clear_c = 0; e_ir = 0; e_rv = 0;
        remaining = 0; since = 0; jlen = 0; e_a = 0; e_b = 0; sum = 0; e_res = 0;
      end else if (init) begin
        chk("busy", longint'(busy), longint'(active));
        chk("in_ready", longint'(in_ready), longint'(e_ir));
        chk("res_valid", longint'(res_valid), longint'(e_rv));
        chk("dsp_ce", longint'(dsp_ce), longint'(active));
        chk("dsp_opmode", longint'(dsp_opmode), active ? longint'(OP_MAC) : longint'(OP_IDLE));
        chk("dsp_rstp", longint'(dsp_rstp), longint'(clear_c));
        chk("dsp_a", longint'(dsp_a), e_a);
        chk("dsp_b", longint'(dsp_b), e_b);
        chk("result", longint'(result), e_res);

        xfer = in_valid && e_ir;
        e_a  = xfer ? longint'(in_a) : 0;
        e_b  = xfer ? longint'(in_b) : 0;
        if (!active) begin
          clear_c = 0;
          if (start) begin
            active = 1; jlen = int'(len); remaining = int'(len);
            sum = 0; since = 0; clear_c = (len != 8'd0);
          end
        end else begin
          clear_c = 0;
          if (xfer) begin
            sum += longint'(in_a) * longint'(in_b);
            remaining--;
            since = 0;
          end else begin
            since++;
          end
          if (e_rv && res_ready) begin
            jobs++;
            $display("job %0d: len=%0d result=%0d model=%0d", jobs, jlen, result, e_res);
            if (lit_seq != done_seq) begin
              chk("literal_result", longint'(result), lit_val);
              done_seq = lit_seq;
            end
            active = 0;
          end
        end
        new_rv = active && (remaining == 0) && (since >= ((jlen == 0) ? 0 : LAT + 1));
        if (new_rv && !e_rv) e_res = sum;
        e_rv = new_rv;
        e_ir = active && !clear_c && (remaining != 0);
      end
    end
  end

  task automatic arm(input longint v);
    lit_val = v;
    lit_seq++;
  endtask

  task automatic go(input int l);
    start = 1'b1;
    len   = 8'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int a, input int b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = 18'(a);
    in_b     = 18'(b);
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        $display("FAIL feed_timeout: in_ready=%0d, required 1", in_ready);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // Waits for res_valid, stalls res_ready for 'hold' cycles (optionally
  // poking start meanwhile), then completes the handshake.
  task automatic finish_job(input int hold, input bit poke);
    int n = 0;
    while (!res_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 400) begin
        $display("FAIL done_timeout: res_valid=%0d, required 1", res_valid);
        $fatal(1);
      end
    end
    for (int i = 0; i < hold; i++) begin
      start = poke && (i % 2 == 0);
      len   = 8'd7;
      @(posedge clk); #1;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    arm(20); go(3); feed(2, 3); feed(4, 5); feed(-1, 6); finish_job(0, 1'b0);

    arm(50); go(2); feed(7, 7);
    @(posedge clk); #1;
    feed(1, 1); finish_job(0, 1'b0);

    arm(0); go(0); finish_job(0, 1'b0);

    arm(18); go(2); feed(3, -4); feed(5, 6); finish_job(5, 1'b1);
    @(posedge clk); #1;

    res_ready = 1'b1;
    arm(-18); go(1); feed(2, -9); finish_job(0, 1'b0);

    go(4); feed(5, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    arm(9); go(1); feed(3, 3); finish_job(0, 1'b0);

    arm(131072); go(2); feed(-131072, -131072); feed(131071, -131072); finish_job(1, 1'b0);

    arm(255); go(255);
    for (int i = 0; i < 255; i++) feed(1, 1);
    finish_job(0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
